multicycle_ctrl: RTL



---
 rtl/rv_ctrl_pkg.sv | 50 +++++
 rtl/multicycle_ctrl_if.sv | 12 +
 rtl/alu_decode.sv | 35 +++
 rtl/multicycle_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared control-path definitions for the RV32I sequencer and decoders:
// opcodes, ALU codes, mux selects, FSM state codes and trap causes.
package rv_ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_FETCH  = 3'd1;
    localparam state_t S_DECODE = 3'd2;
    localparam state_t S_EXEC   = 3'd3;
    localparam state_t S_MEM    = 3'd4;
    localparam state_t S_WB     = 3'd5;
    localparam state_t S_TRAP   = 3'd6;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    function automatic logic op_supported(input logic [6:0] op);
        return op inside {R_TYPE, I_TYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory request-acknowledge bundle between the sequencer
// (master) and the memory side (slave).
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_ack;
    logic memwrite;

    modport master (output imem_req, dmem_req, memwrite, input imem_ack, dmem_ack);
    modport slave  (input imem_req, dmem_req, memwrite, output imem_ack, dmem_ack);
endinterface

// File: rtl/alu_decode.sv
// Combinational ALU-control decoder shared by the single- and multi-cycle
// control paths; flags R/I-ALU encodings the ALU cannot execute.
module alu_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] aluctl,
    output logic       illegal
);
    logic is_r;
    assign is_r = (opcode == R_TYPE);

    always_comb begin
        aluctl  = ALU_ADD;
        illegal = 1'b0;
        if (opcode == R_TYPE || opcode == I_TYPE) begin
            // funct7 only qualifies R-type; for I-type those bits are immediate
            case (funct3)
                3'b000: begin
                    if (is_r && funct7 == F7_SUB) aluctl = ALU_SUB;
                    else if (is_r && funct7 != F7_BASE) illegal = 1'b1;
                end
                3'b111: aluctl = ALU_AND;
                3'b110: aluctl = ALU_OR;
                3'b010: aluctl = ALU_SLT;
                default: illegal = 1'b1;
            endcase
            if (is_r && funct3 != 3'b000 && funct7 != F7_BASE) illegal = 1'b1;
        end else if (opcode == BRANCH) begin
            aluctl = ALU_SUB;
        end
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and traps on illegal encodings or ack timeouts.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    multicycle_ctrl_if.master mem,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              zero,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              regwrite,
    output logic [1:0]        wb_sel,
    output logic              alusrc,
    output logic [3:0]        aluctl,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [CNT_W-1:0]  instret
);
    localparam int unsigned       WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [6:0]        op_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        cause_q, cause_nx;
    logic [3:0]        dec_aluctl;
    logic              dec_illegal;
    logic              wait_expired;
    logic              br_taken;

    alu_decode u_alu_decode (
        .opcode  (op_q),
        .funct3  (funct3),
        .funct7  (funct7),
        .aluctl  (dec_aluctl),
        .illegal (dec_illegal)
    );

    assign wait_expired = (wait_cnt == WAIT_LAST);
    assign br_taken     = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
    assign trap_cause   = cause_q;

    always_comb begin
        state_nx     = state;
        cause_nx     = cause_q;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.memwrite = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        regwrite     = 1'b0;
        wb_sel       = WB_ALU;
        alusrc       = 1'b0;
        aluctl       = '0;
        trap         = 1'b0;
        case (state)
            S_IDLE: if (run) state_nx = S_FETCH;
            S_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ack) begin
                    ir_we    = 1'b1;
                    state_nx = S_DECODE;
                end else if (wait_expired) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_IMEM;
                end
            end
            S_DECODE: begin
                if (!op_supported(opcode) || (opcode == BRANCH && funct3[2:1] != 2'b00)) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_ILLEGAL;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                aluctl = dec_aluctl;
                alusrc = op_q inside {I_TYPE, LOAD, STORE, JALR, LUI};
                if (dec_illegal) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_ILLEGAL;
                end else if (op_q == BRANCH) begin
                    pc_we    = 1'b1;
                    pc_sel   = br_taken ? PC_TARGET : PC_PLUS4;
                    state_nx = S_FETCH;
                end else if (op_q == LOAD || op_q == STORE) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.memwrite = (op_q == STORE);
                if (mem.dmem_ack) begin
                    pc_we    = (op_q == STORE);
                    state_nx = (op_q == STORE) ? S_FETCH : S_WB;
                end else if (wait_expired) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_DMEM;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                pc_we    = 1'b1;
                state_nx = S_FETCH;
                case (op_q)
                    LOAD: wb_sel = WB_MEM;
                    JAL: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_TARGET;
                    end
                    JALR: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_ALU;
                    end
                    LUI: wb_sel = WB_IMM;
                    default: ;
                endcase
            end
            S_TRAP: trap = 1'b1;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            wait_cnt <= '0;
            cause_q  <= CAUSE_NONE;
            instret  <= '0;
        end else begin
            state   <= state_nx;
            cause_q <= cause_nx;
            if (state == S_DECODE) op_q <= opcode;
            // any state change restarts the wait window, covering entry to FETCH and MEM
            if (state_nx != state) wait_cnt <= '0;
            else if (state == S_FETCH || state == S_MEM) wait_cnt <= wait_cnt + WAIT_W'(1);
            if (pc_we) instret <= instret + CNT_W'(1);
        end
    end
endmodule
